// File: rtl/core_sram_responder.sv
`default_nettype none
// ============================================================================
// core_sram_responder : single-port 32-bit SRAM shared by a core port and a
// Wishbone-bridge host port with round-robin arbitration. Optional macro
// CORE_SRAM_OUTREG_EN adds an output register stage (2-cycle latency).
// Revision: 1.0
// ============================================================================
module core_sram_responder #(
  parameter int ADDR_W = 10
) (
  input  logic              wb_clk_i,
  input  logic              wb_rst_i,

  input  logic              core_data_req_i,
  input  logic              core_data_we_i,
  input  logic [ADDR_W-1:0] core_data_addr_i,
  input  logic [3:0]        core_data_be_i,
  input  logic [31:0]       core_data_wdata_i,
  output logic              core_data_gnt_o,
  output logic              core_data_rvalid_o,
  output logic [31:0]       core_data_rdata_o,

  input  logic              host_data_req_i,
  input  logic              host_data_we_i,
  input  logic [ADDR_W-1:0] host_data_addr_i,
  input  logic [3:0]        host_data_be_i,
  input  logic [31:0]       host_data_wdata_i,
  output logic              host_data_gnt_o,
  output logic              host_data_rvalid_o,
  output logic [31:0]       host_data_rdata_o
);

  localparam int DEPTH = 2**ADDR_W;

  logic [31:0]       r_mem [DEPTH];
  logic              r_last_core;
  logic              r_core_rvalid;
  logic              r_host_rvalid;
  logic [31:0]       r_core_rdata;
  logic [31:0]       r_host_rdata;

  logic              w_host_blocked;
  logic              w_core_elig;
  logic              w_host_elig;
  logic              w_gnt_core;
  logic              w_gnt_host;
  logic              w_gnt_any;
  logic              w_we;
  logic [ADDR_W-1:0] w_addr;
  logic [3:0]        w_be;
  logic [31:0]       w_wdata;
  logic [31:0]       w_rsp;

  assign w_core_elig = core_data_req_i;
  assign w_host_elig = host_data_req_i & ~w_host_blocked;

  always_comb begin
    w_gnt_core = 1'b0;
    w_gnt_host = 1'b0;
    if (!wb_rst_i) begin
      if (w_core_elig && w_host_elig) begin
        // Contention: favour whichever port lost the previous grant.
        w_gnt_core = ~r_last_core;
        w_gnt_host = r_last_core;
      end else begin
        w_gnt_core = w_core_elig;
        w_gnt_host = w_host_elig;
      end
    end
  end

  assign w_gnt_any = w_gnt_core | w_gnt_host;
  assign w_we      = w_gnt_host ? host_data_we_i    : core_data_we_i;
  assign w_addr    = w_gnt_host ? host_data_addr_i  : core_data_addr_i;
  assign w_be      = w_gnt_host ? host_data_be_i    : core_data_be_i;
  assign w_wdata   = w_gnt_host ? host_data_wdata_i : core_data_wdata_i;
  assign w_rsp     = w_we ? 32'h0 : r_mem[w_addr];

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      r_last_core <= 1'b0;
    end else if (w_gnt_any) begin
      r_last_core <= w_gnt_core;
    end
  end

  always_ff @(posedge wb_clk_i) begin
    if (w_gnt_any && w_we) begin
      for (int i = 0; i < 4; i++) begin
        if (w_be[i]) begin
          r_mem[w_addr][8*i +: 8] <= w_wdata[8*i +: 8];
        end
      end
    end
  end

`ifdef CORE_SRAM_OUTREG_EN
  logic        r_s1_core;
  logic        r_s1_host;
  logic [31:0] r_s1_data;

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      r_s1_core <= 1'b0;
      r_s1_host <= 1'b0;
      r_s1_data <= 32'h0;
    end else begin
      r_s1_core <= w_gnt_core;
      r_s1_host <= w_gnt_host;
      if (w_gnt_any) begin
        r_s1_data <= w_rsp;
      end
    end
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      r_core_rvalid <= 1'b0;
      r_host_rvalid <= 1'b0;
      r_core_rdata  <= 32'h0;
      r_host_rdata  <= 32'h0;
    end else begin
      r_core_rvalid <= r_s1_core;
      r_host_rvalid <= r_s1_host;
      if (r_s1_core) begin
        r_core_rdata <= r_s1_data;
      end
      if (r_s1_host) begin
        r_host_rdata <= r_s1_data;
      end
    end
  end

  // Host is still holding stb/cyc while its access is in flight.
  assign w_host_blocked = host_data_rvalid_o | r_s1_host;
`else
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      r_core_rvalid <= 1'b0;
      r_host_rvalid <= 1'b0;
      r_core_rdata  <= 32'h0;
      r_host_rdata  <= 32'h0;
    end else begin
      r_core_rvalid <= w_gnt_core;
      r_host_rvalid <= w_gnt_host;
      if (w_gnt_core) begin
        r_core_rdata <= w_rsp;
      end
      if (w_gnt_host) begin
        r_host_rdata <= w_rsp;
      end
    end
  end

  assign w_host_blocked = host_data_rvalid_o;
`endif

  // Masking with reset drops a response that would otherwise land in the reset cycle.
  assign core_data_gnt_o    = w_gnt_core;
  assign host_data_gnt_o    = w_gnt_host;
  assign core_data_rvalid_o = r_core_rvalid & ~wb_rst_i;
  assign host_data_rvalid_o = r_host_rvalid & ~wb_rst_i;
  assign core_data_rdata_o  = wb_rst_i ? 32'h0 : r_core_rdata;
  assign host_data_rdata_o  = wb_rst_i ? 32'h0 : r_host_rdata;

endmodule
`default_nettype wire

// File: tb/tb_core_sram_responder.sv
`default_nettype none
// Bench for core_sram_responder: directed stimulus, per-cycle comparison against
// a transaction-level model, plus literal checks of the key scenarios.
module tb_core_sram_responder;

  localparam int ADDR_W = 10;
`ifdef CORE_SRAM_OUTREG_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  logic clk = 1'b0;
  logic rst;
  logic c_req, c_we, h_req, h_we;
  logic [ADDR_W-1:0] c_addr, h_addr;
  logic [3:0] c_be, h_be;
  logic [31:0] c_wd, h_wd;
  logic core_gnt, core_rv, host_gnt, host_rv;
  logic [31:0] core_rd, host_rd;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;

  core_sram_responder #(.ADDR_W(ADDR_W)) dut (
    .wb_clk_i          (clk),
    .wb_rst_i          (rst),
    .core_data_req_i   (c_req),
    .core_data_we_i    (c_we),
    .core_data_addr_i  (c_addr),
    .core_data_be_i    (c_be),
    .core_data_wdata_i (c_wd),
    .core_data_gnt_o   (core_gnt),
    .core_data_rvalid_o(core_rv),
    .core_data_rdata_o (core_rd),
    .host_data_req_i   (h_req),
    .host_data_we_i    (h_we),
    .host_data_addr_i  (h_addr),
    .host_data_be_i    (h_be),
    .host_data_wdata_i (h_wd),
    .host_data_gnt_o   (host_gnt),
    .host_data_rvalid_o(host_rv),
    .host_data_rdata_o (host_rd)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- transaction-level model ----------------
  typedef struct {
    int          due;
    bit          host;
    logic [31:0] data;
    bit          known;
  } resp_t;

  resp_t       q[$];
  logic [31:0] m_mem [1024];
  bit   [3:0]  m_kn  [1024];
  bit          last_core = 1'b0;
  logic [31:0] hold_c = 32'h0, hold_h = 32'h0;
  bit          hk_c = 1'b1, hk_h = 1'b1;

  always @(negedge clk) begin
    bit host_out, eg_c, eg_h, ev_c, ev_h, we;
    logic [ADDR_W-1:0] a;
    logic [3:0] be;
    logic [31:0] wd;
    resp_t r;
    cyc++;
    host_out = 1'b0;
    foreach (q[i]) if (q[i].host) host_out = 1'b1;
    eg_c = 1'b0;
    eg_h = 1'b0;
    if (!rst) begin
      if (c_req && h_req && !host_out) begin
        eg_c = !last_core;
        eg_h = last_core;
      end else begin
        eg_c = c_req;
        eg_h = h_req && !host_out;
      end
    end
    ev_c = 1'b0;
    ev_h = 1'b0;
    if (!rst) begin
      while (q.size() > 0 && q[0].due == cyc) begin
        r = q.pop_front();
        if (r.host) begin ev_h = 1'b1; hold_h = r.data; hk_h = r.known; end
        else        begin ev_c = 1'b1; hold_c = r.data; hk_c = r.known; end
      end
    end
    chk("core_gnt", core_gnt, eg_c);
    chk("host_gnt", host_gnt, eg_h);
    chk("core_rvalid", core_rv, ev_c);
    chk("host_rvalid", host_rv, ev_h);
    if (rst) begin
      chk("core_rdata_rst", core_rd, 32'h0);
      chk("host_rdata_rst", host_rd, 32'h0);
    end else begin
      if (hk_c) chk("core_rdata", core_rd, hold_c);
      if (hk_h) chk("host_rdata", host_rd, hold_h);
    end
    if (rst) begin
      q.delete();
      hold_c = 32'h0; hold_h = 32'h0;
      hk_c = 1'b1; hk_h = 1'b1;
      last_core = 1'b0;
    end else if (eg_c || eg_h) begin
      we = eg_h ? h_we : c_we;
      a  = eg_h ? h_addr : c_addr;
      be = eg_h ? h_be : c_be;
      wd = eg_h ? h_wd : c_wd;
      r.due  = cyc + LAT;
      r.host = eg_h;
      if (we) begin
        for (int b = 0; b < 4; b++) begin
          if (be[b]) begin
            m_mem[a][8*b +: 8] = wd[8*b +: 8];
            m_kn[a][b] = 1'b1;
          end
        end
        r.data  = 32'h0;
        r.known = 1'b1;
      end else begin
        r.data  = m_mem[a];
        r.known = &m_kn[a];
      end
      q.push_back(r);
      last_core = eg_c;
    end
  end

  // ---------------- stimulus ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input bit host, input bit req, input bit we,
                       input logic [ADDR_W-1:0] a, input logic [3:0] be, input logic [31:0] d);
    if (host) begin h_req = req; h_we = we; h_addr = a; h_be = be; h_wd = d; end
    else      begin c_req = req; c_we = we; c_addr = a; c_be = be; c_wd = d; end
  endtask

  task automatic wait_rv(input bit host, output int lat, output logic [31:0] d);
    lat = -1;
    d = 32'h0;
    for (int k = 1; k <= 6; k++) begin
      #3;
      if (host ? host_rv : core_rv) begin
        lat = k;
        d = host ? host_rd : core_rd;
        break;
      end
      step();
    end
  endtask

  task automatic txn(input bit host, input bit we, input logic [ADDR_W-1:0] a,
                     input logic [3:0] be, input logic [31:0] wd, output logic [31:0] d);
    int lat;
    step();
    drive(host, 1'b1, we, a, be, wd);
    #3;
    chk(host ? "host_txn_gnt" : "core_txn_gnt", host ? host_gnt : core_gnt, 32'h1);
    step();
    drive(host, 1'b0, 1'b0, '0, 4'h0, 32'h0);
    wait_rv(host, lat, d);
    chk(host ? "host_txn_latency" : "core_txn_latency", lat, LAT);
  endtask

  initial begin
    logic [31:0] d;
    int grants, rvs;
    bit seen, exp_h;
    rst = 1'b1;
    drive(1'b0, 1'b0, 1'b0, '0, 4'h0, 32'h0);
    drive(1'b1, 1'b0, 1'b0, '0, 4'h0, 32'h0);
    repeat (3) step();
    rst = 1'b0;

    // Core write then read of the same word.
    txn(1'b0, 1'b1, 10'h005, 4'hF, 32'hDEADBEEF, d);
    chk("core_wr_rdata_zero", d, 32'h0);
    txn(1'b0, 1'b0, 10'h005, 4'h0, 32'h0, d);
    chk("core_rd_deadbeef", d, 32'hDEADBEEF);

    // Host partial write, zero-enable write, read back.
    txn(1'b1, 1'b1, 10'h3FF, 4'hF, 32'hAAAAAAAA, d);
    txn(1'b1, 1'b1, 10'h3FF, 4'b0101, 32'h11223344, d);
    txn(1'b1, 1'b1, 10'h3FF, 4'h0, 32'hFFFFFFFF, d);
    txn(1'b1, 1'b0, 10'h3FF, 4'hF, 32'h0, d);
    chk("host_rd_merge", d, 32'hAA22AA44);

    // Core partial write and back-to-back core reads.
    txn(1'b0, 1'b1, 10'h005, 4'b1010, 32'h01020304, d);
    txn(1'b0, 1'b0, 10'h005, 4'h0, 32'h0, d);
    chk("core_rd_partial", d, 32'h01AD03EF);
    step(); drive(1'b0, 1'b1, 1'b0, 10'h005, 4'h0, 32'h0);
    #3 chk("core_b2b_gnt0", core_gnt, 32'h1);
    step(); drive(1'b0, 1'b1, 1'b0, 10'h3FF, 4'h0, 32'h0);
    #3 chk("core_b2b_gnt1", core_gnt, 32'h1);
    step(); drive(1'b0, 1'b0, 1'b0, '0, 4'h0, 32'h0);
    repeat (3) step();

    // Continuous contention straight out of reset.
    rst = 1'b1;
    repeat (2) step();
    rst = 1'b0;
    for (int i = 0; i < 9; i++) begin
      drive(1'b0, 1'b1, 1'b1, 10'h010, 4'hF, 32'h10000000 + i);
      drive(1'b1, 1'b1, 1'b0, 10'h010, 4'h0, 32'h0);
      exp_h = (LAT == 1) ? (i % 2 == 1) : (i % 3 == 1);
      #3;
      chk("rr_core_gnt", core_gnt, !exp_h);
      chk("rr_host_gnt", host_gnt, exp_h);
      step();
    end
    drive(1'b0, 1'b0, 1'b0, '0, 4'h0, 32'h0);
    drive(1'b1, 1'b0, 1'b0, '0, 4'h0, 32'h0);
    repeat (4) step();

    // Wishbone-style host holds req through its ack cycle.
    drive(1'b1, 1'b1, 1'b0, 10'h005, 4'h0, 32'h0);
    grants = 0; rvs = 0; seen = 1'b0;
    for (int k = 0; k < 8; k++) begin
      #3;
      grants += int'(host_gnt);
      rvs    += int'(host_rv);
      if (host_rv) seen = 1'b1;
      step();
      if (seen) drive(1'b1, 1'b0, 1'b0, '0, 4'h0, 32'h0);
    end
    chk("wb_host_grants", grants, 32'd1);
    chk("wb_host_acks", rvs, 32'd1);

    // Reset right after a granted write; write attempted during reset.
    txn(1'b0, 1'b1, 10'h020, 4'hF, 32'h55555555, d);
    step(); drive(1'b0, 1'b1, 1'b1, 10'h020, 4'hF, 32'h12345678);
    #3 chk("rst_pre_gnt", core_gnt, 32'h1);
    step(); rst = 1'b1; drive(1'b0, 1'b1, 1'b1, 10'h020, 4'hF, 32'hCAFEF00D);
    #3;
    chk("rst_core_rvalid", core_rv, 32'h0);
    chk("rst_core_rdata", core_rd, 32'h0);
    chk("rst_core_gnt", core_gnt, 32'h0);
    step(); rst = 1'b0; drive(1'b0, 1'b0, 1'b0, '0, 4'h0, 32'h0);
    #3 chk("post_rst_rvalid", core_rv, 32'h0);
    txn(1'b0, 1'b0, 10'h020, 4'h0, 32'h0, d);
    chk("rst_write_ignored", d, 32'h12345678);

    repeat (3) step();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: bench did not finish (cycle %0d)", cyc);
    $fatal(1);
  end

endmodule
`default_nettype wire
